// File: rtl/pll_lock_ctrl_pkg.sv
// pll_lock_ctrl shared types: sequencer states and counter width helper.
// Used by pll_lock_ctrl and its testbench-free submodules.
package pll_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    RST,
    WAIT,
    LOCKED,
    STBY,
    FAULT
  } state_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous status bits.
// Both flops reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset/standby sequencer and lock supervisor.
// Optional lock-loss counter: define PLL_LOCK_CTRL_LOSS_CNT_EN.
module pll_lock_ctrl
  import pll_lock_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 8
) (
  input  logic                          refclk,
  input  logic                          rst_n,
  input  logic                          extlock,
  input  logic                          stdby_req,
  input  logic                          relock_req,
  output logic                          pll_reset,
  output logic                          pll_stdby,
  output logic                          locked,
  output logic                          fault,
  output logic [cnt_w(MAX_RETRY)-1:0]   retry_cnt
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
  ,
  output logic [CNT_W-1:0]              loss_cnt
`endif
);

  localparam int CMAX = (RST_CYCLES > TIMEOUT_CYCLES)
                      ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = cnt_w(CMAX);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int RW = cnt_w(MAX_RETRY);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STB_DONE = SW'(STABLE_CYCLES);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  state_e          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [SW-1:0]   stb_q, stb_d;
  logic [RW-1:0]   retry_d;
  logic [RW-1:0]   retry_inc;
  logic            lock_s;

  sync2 u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (extlock),
    .q     (lock_s)
  );

  assign retry_inc = retry_cnt + RW'(1);

  // State, cycle/stable counters and retry count.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST;
      cyc_q     <= '0;
      stb_q     <= '0;
      retry_cnt <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      retry_cnt <= retry_d;
    end
  end

  // Next state; counters clear on every transition.
  always_comb begin
    state_d = state_q;
    cyc_d   = '0;
    stb_d   = '0;
    retry_d = retry_cnt;
    unique case (state_q)
      RST: begin
        if (stdby_req)             state_d = STBY;
        else if (relock_req)       state_d = RST;
        else if (cyc_q == RST_LAST) state_d = WAIT;
        else                       cyc_d = cyc_q + CW'(1);
      end
      WAIT: begin
        if (stdby_req) begin
          state_d = STBY;
        end else if (relock_req) begin
          state_d = RST;
        end else if (stb_q == STB_DONE) begin
          state_d = LOCKED;
          retry_d = '0;
        end else if (cyc_q == TMO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RTY_MAX) ? FAULT : RST;
        end else begin
          cyc_d = cyc_q + CW'(1);
          stb_d = lock_s ? stb_q + SW'(1) : '0;
        end
      end
      LOCKED: begin
        if (stdby_req)       state_d = STBY;
        else if (!lock_s)    state_d = RST;
        else if (relock_req) state_d = RST;
      end
      STBY: begin
        if (!stdby_req) state_d = RST;
      end
      FAULT: begin
        if (relock_req) begin
          state_d = RST;
          retry_d = '0;
        end
      end
      default: state_d = RST;
    endcase
  end

  // Registered Moore decode of the state being entered.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset <= 1'b1;
      pll_stdby <= 1'b0;
      locked    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pll_reset <= (state_d == RST) || (state_d == FAULT);
      pll_stdby <= (state_d == STBY);
      locked    <= (state_d == LOCKED);
      fault     <= (state_d == FAULT);
    end
  end

`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
  logic lost;

  assign lost = (state_q == LOCKED) && !lock_s;

  // Saturating count of lock losses seen while LOCKED.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      loss_cnt <= '0;
    else if (lost && (loss_cnt != '1))
      loss_cnt <= loss_cnt + CNT_W'(1);
  end
`endif

endmodule
